// File: rtl/fetch_unit_pkg.sv
// rtl/fetch_unit_pkg.sv - shared FSM encoding, widths and reset address for the fetch unit
package fetch_unit_pkg;

  localparam int INST_W = 32;
  localparam logic [INST_W-1:0] RESET_PC_DEFAULT = 32'h0000_3000;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  function automatic logic [INST_W-1:0] next_fetch_pc(input logic [INST_W-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// rtl/fetch_unit_if.sv - instruction-memory request and consumer handshake bundle
interface fetch_unit_if;
  import fetch_unit_pkg::*;

  logic              imem_req;
  logic [INST_W-1:0] imem_addr;
  logic              imem_ack;
  logic [INST_W-1:0] imem_rdata;
  logic              inst_valid;
  logic              inst_ready;
  logic [INST_W-1:0] inst;
  logic [INST_W-1:0] inst_pc;

  modport master (
    output imem_req, imem_addr, inst_valid, inst, inst_pc,
    input  imem_ack, imem_rdata, inst_ready
  );

  modport slave (
    input  imem_req, imem_addr, inst_valid, inst, inst_pc,
    output imem_ack, imem_rdata, inst_ready
  );

endinterface

// File: rtl/fetch_fifo.sv
// rtl/fetch_fifo.sv - circular instruction buffer holding word and fetch address per entry
module fetch_fifo
  import fetch_unit_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              push,
  input  logic [INST_W-1:0] push_data,
  input  logic [INST_W-1:0] push_pc,
  input  logic              pop,
  output logic [INST_W-1:0] head_data,
  output logic [INST_W-1:0] head_pc,
  output logic [CW-1:0]     count
);

  logic [INST_W-1:0] data_mem [DEPTH];
  logic [INST_W-1:0] pc_mem   [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic              do_push;
  logic              do_pop;

  // flush wins over both push and pop in the same cycle
  assign do_push = push && !flush;
  assign do_pop  = pop && !flush && (count != '0);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      data_mem[wr_ptr] <= push_data;
      pc_mem[wr_ptr]   <= push_pc;
    end
  end

  assign head_data = data_mem[rd_ptr];
  assign head_pc   = pc_mem[rd_ptr];

endmodule

// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - single-outstanding instruction fetch FSM feeding fetch_fifo
// FETCH_ALIGN_CHECK_EN adds the fetch_misalign output and misaligned-redirect halt.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int                DEPTH    = 4,
  parameter logic [INST_W-1:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              redirect,
  input  logic [INST_W-1:0] redirect_pc,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic              fetch_misalign,
`endif
  fetch_unit_if.master      bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  fetch_state_e      state, state_next;
  logic [INST_W-1:0] fetch_pc, fetch_pc_next;
  logic [INST_W-1:0] req_addr, req_addr_next;
  logic [INST_W-1:0] redirect_target;
  logic              misalign_next;
  logic              push;
  logic              pop;
  logic [CW-1:0]     count;
  logic [INST_W-1:0] head_data;
  logic [INST_W-1:0] head_pc;

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign;

  assign redirect_target = redirect_pc;
  assign misalign_next   = redirect ? (redirect_pc[1:0] != 2'b00) : misalign;
  assign fetch_misalign  = misalign;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) misalign <= 1'b0;
    else        misalign <= misalign_next;
  end
`else
  assign redirect_target = redirect_pc & ~32'h0000_0003;
  assign misalign_next   = 1'b0;
`endif

  // req_addr freezes the issued address so a redirect cannot disturb an outstanding request
  always_comb begin
    state_next    = state;
    fetch_pc_next = fetch_pc;
    req_addr_next = req_addr;
    push          = 1'b0;
    case (state)
      ST_IDLE: begin
        if (redirect) fetch_pc_next = redirect_target;
        if ((redirect || (count < DEPTH_C)) && !misalign_next) begin
          state_next    = ST_WAIT;
          req_addr_next = fetch_pc_next;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          fetch_pc_next = redirect_target;
          state_next    = bus.imem_ack ? ST_IDLE : ST_DROP;
        end else if (bus.imem_ack) begin
          push          = 1'b1;
          fetch_pc_next = next_fetch_pc(req_addr);
          state_next    = ST_IDLE;
        end
      end
      ST_DROP: begin
        if (redirect)     fetch_pc_next = redirect_target;
        if (bus.imem_ack) state_next    = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= ST_IDLE;
      fetch_pc <= RESET_PC;
      req_addr <= RESET_PC;
    end else begin
      state    <= state_next;
      fetch_pc <= fetch_pc_next;
      req_addr <= req_addr_next;
    end
  end

  assign pop = bus.inst_valid && bus.inst_ready;

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (redirect),
    .push      (push),
    .push_data (bus.imem_rdata),
    .push_pc   (req_addr),
    .pop       (pop),
    .head_data (head_data),
    .head_pc   (head_pc),
    .count     (count)
  );

  assign bus.imem_req   = (state != ST_IDLE);
  assign bus.imem_addr  = (state == ST_IDLE) ? fetch_pc : req_addr;
  assign bus.inst_valid = (count != '0);
  assign bus.inst       = head_data;
  assign bus.inst_pc    = head_pc;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - directed vector table plus corner-case sequences for fetch_unit
module tb_fetch_unit;

  logic        clk;
  logic        reset;
  logic        redirect;
  logic [31:0] redirect_pc;
`ifdef FETCH_ALIGN_CHECK_EN
  logic        fetch_misalign;
`endif

  int checks;
  int failures;

  fetch_unit_if bus_if ();

  fetch_unit #(
    .DEPTH    (4),
    .RESET_PC (32'h0000_3000)
  ) dut (
    .clk            (clk),
    .reset          (reset),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
`ifdef FETCH_ALIGN_CHECK_EN
    .fetch_misalign (fetch_misalign),
`endif
    .bus            (bus_if.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        ack;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_inst;
    logic [31:0] exp_pc;
  } vec_t;

  vec_t vecs [17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_out(input string tag, input logic req, input logic [31:0] addr, input logic valid);
    check({tag, "_req"},   32'(bus_if.imem_req),   32'(req));
    check({tag, "_addr"},  bus_if.imem_addr,       addr);
    check({tag, "_valid"}, 32'(bus_if.inst_valid), 32'(valid));
  endtask

  task automatic check_head(input string tag, input logic [31:0] inst, input logic [31:0] pc);
    check({tag, "_inst"}, bus_if.inst,    inst);
    check({tag, "_pc"},   bus_if.inst_pc, pc);
  endtask

  task automatic do_reset();
    reset              = 1'b0;
    redirect           = 1'b0;
    redirect_pc        = '0;
    bus_if.imem_ack    = 1'b0;
    bus_if.imem_rdata  = '0;
    bus_if.inst_ready  = 1'b0;
    tick();
    tick();
    check_out("rst", 1'b0, 32'h0000_3000, 1'b0);
`ifdef FETCH_ALIGN_CHECK_EN
    check("rst_misalign", 32'(fetch_misalign), 32'd0);
`endif
    reset = 1'b1;
  endtask

  task automatic fetch_one(input logic [31:0] word);
    bus_if.imem_ack = 1'b0;
    tick();
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = word;
    tick();
    bus_if.imem_ack = 1'b0;
  endtask

  task automatic set_vec(input int i, input logic ack, input logic [31:0] rdata, input logic ready,
                         input logic ereq, input logic [31:0] eaddr, input logic evalid,
                         input logic [31:0] einst, input logic [31:0] epc);
    vecs[i] = '{ack, rdata, ready, ereq, eaddr, evalid, einst, epc};
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    checks   = 0;
    failures = 0;

    // first fetch, fill to DEPTH, stall, then pop/push overlap and drain
    set_vec( 0, 0, 32'h0,         0, 0, 32'h3000, 0, 32'h0,         32'h0);
    set_vec( 1, 1, 32'h3C01_0001, 0, 1, 32'h3000, 0, 32'h0,         32'h0);
    set_vec( 2, 0, 32'h0,         0, 0, 32'h3004, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 3, 1, 32'hA000_0001, 0, 1, 32'h3004, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 4, 0, 32'h0,         0, 0, 32'h3008, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 5, 1, 32'hA000_0002, 0, 1, 32'h3008, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 6, 0, 32'h0,         0, 0, 32'h300C, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 7, 1, 32'hA000_0003, 0, 1, 32'h300C, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 8, 0, 32'h0,         0, 0, 32'h3010, 1, 32'h3C01_0001, 32'h3000);
    set_vec( 9, 0, 32'h0,         1, 0, 32'h3010, 1, 32'h3C01_0001, 32'h3000);
    set_vec(10, 0, 32'h0,         0, 0, 32'h3010, 1, 32'hA000_0001, 32'h3004);
    set_vec(11, 1, 32'hA000_0004, 1, 1, 32'h3010, 1, 32'hA000_0001, 32'h3004);
    set_vec(12, 0, 32'h0,         1, 0, 32'h3014, 1, 32'hA000_0002, 32'h3008);
    set_vec(13, 0, 32'h0,         1, 1, 32'h3014, 1, 32'hA000_0003, 32'h300C);
    set_vec(14, 0, 32'h0,         1, 1, 32'h3014, 1, 32'hA000_0004, 32'h3010);
    set_vec(15, 1, 32'hA000_0005, 1, 1, 32'h3014, 0, 32'h0,         32'h0);
    set_vec(16, 0, 32'h0,         0, 0, 32'h3018, 1, 32'hA000_0005, 32'h3014);

    do_reset();
    for (int i = 0; i < 17; i++) begin
      check_out($sformatf("v%0d", i), vecs[i].exp_req, vecs[i].exp_addr, vecs[i].exp_valid);
      if (vecs[i].exp_valid)
        check_head($sformatf("v%0d", i), vecs[i].exp_inst, vecs[i].exp_pc);
      bus_if.imem_ack   = vecs[i].ack;
      bus_if.imem_rdata = vecs[i].rdata;
      bus_if.inst_ready = vecs[i].ready;
      tick();
    end
    bus_if.imem_ack   = 1'b0;
    bus_if.inst_ready = 1'b0;

    // redirect while waiting: address held, late ack discarded, restart at target
    do_reset();
    tick();
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3100;
    tick();
    redirect = 1'b0;
    check_out("drop_hold", 1'b1, 32'h0000_3000, 1'b0);
    tick();
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hDEAD_BEEF;
    tick();
    bus_if.imem_ack = 1'b0;
    check_out("drop_ack", 1'b0, 32'h0000_3100, 1'b0);
    tick();
    check_out("drop_next", 1'b1, 32'h0000_3100, 1'b0);

    // redirect in the ack cycle with a loaded buffer and a pop pending
    do_reset();
    fetch_one(32'hB000_0000);
    fetch_one(32'hB000_0001);
    fetch_one(32'hB000_0002);
    tick();
    check_out("ackred_pre", 1'b1, 32'h0000_300C, 1'b1);
    check_head("ackred_pre", 32'hB000_0000, 32'h0000_3000);
    redirect          = 1'b1;
    redirect_pc       = 32'h0000_5000;
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hBAD0_0BAD;
    bus_if.inst_ready = 1'b1;
    tick();
    redirect          = 1'b0;
    bus_if.imem_ack   = 1'b0;
    bus_if.inst_ready = 1'b0;
    check_out("ackred_post", 1'b0, 32'h0000_5000, 1'b0);
    tick();
    check_out("ackred_req", 1'b1, 32'h0000_5000, 1'b0);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'h5555_0001;
    tick();
    bus_if.imem_ack = 1'b0;
    check_out("ackred_fill", 1'b0, 32'h0000_5004, 1'b1);
    check_head("ackred_fill", 32'h5555_0001, 32'h0000_5000);

    // redirect from idle with one entry buffered; fetch_pc wraps past 0xFFFF_FFFC
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check_out("wrap_req", 1'b1, 32'hFFFF_FFFC, 1'b0);
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'h7777_0007;
    tick();
    bus_if.imem_ack = 1'b0;
    check_out("wrap_push", 1'b0, 32'h0000_0000, 1'b1);
    check_head("wrap_push", 32'h7777_0007, 32'hFFFF_FFFC);
    tick();
    check_out("wrap_next", 1'b1, 32'h0000_0000, 1'b1);

`ifdef FETCH_ALIGN_CHECK_EN
    bus_if.imem_ack = 1'b1;
    tick();
    bus_if.imem_ack = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3002;
    tick();
    redirect = 1'b0;
    check("mis_set", 32'(fetch_misalign), 32'd1);
    check("mis_noreq0", 32'(bus_if.imem_req), 32'd0);
    tick();
    check("mis_hold", 32'(fetch_misalign), 32'd1);
    check("mis_noreq1", 32'(bus_if.imem_req), 32'd0);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3008;
    tick();
    redirect = 1'b0;
    check("mis_clear", 32'(fetch_misalign), 32'd0);
    check_out("mis_req", 1'b1, 32'h0000_3008, 1'b0);
`else
    bus_if.imem_ack = 1'b1;
    tick();
    bus_if.imem_ack = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_3202;
    tick();
    redirect = 1'b0;
    check_out("align_force", 1'b1, 32'h0000_3200, 1'b0);
`endif

    // asynchronous reset abandons the outstanding request; stale ack is ignored
    #2;
    reset = 1'b0;
    #1;
    check_out("arst", 1'b0, 32'h0000_3000, 1'b0);
    tick();
    bus_if.imem_ack   = 1'b1;
    bus_if.imem_rdata = 32'hBEEF_0000;
    reset             = 1'b1;
    tick();
    bus_if.imem_ack = 1'b0;
    check_out("arst_restart", 1'b1, 32'h0000_3000, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter DEPTH, default 4, SHALL set the instruction buffer depth in entries; it SHALL be a power of two and at least 2.
REQ-002 Parameter RESET_PC, default 32'h0000_3000, SHALL set the first fetch address after reset.
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on its rising edge.
REQ-004 reset  input  1  SHALL be the asynchronous, active-low reset.
REQ-005 imem_req  output  1  SHALL indicate a valid instruction-memory read request.
REQ-006 imem_addr  output  32  SHALL carry the word address of the request.
REQ-007 imem_ack  input  1  SHALL complete the request in any cycle where imem_req=1; imem_rdata is valid in that cycle.
REQ-008 imem_rdata  input  32  SHALL carry the returned instruction word.
REQ-009 redirect / redirect_pc  input  1 / 32  SHALL request a fetch restart at redirect_pc (branch, jump, exception).
REQ-010 inst_valid / inst_ready  output / input  1 / 1  SHALL form the consumer handshake; transfer when both are 1.
REQ-011 inst / inst_pc  output  32 / 32  SHALL present the buffer head word and its fetch address.

Function
REQ-012 Request FSM SHALL have states IDLE (no request outstanding), WAIT (request outstanding, response kept), DROP (request outstanding, response discarded).
REQ-013 IDLE->WAIT SHALL occur when count+0 < DEPTH and no misalign halt; imem_req=1 and imem_addr=fetch_pc are asserted in WAIT/DROP only.
REQ-014 imem_req and imem_addr SHALL hold stable from assertion until the ack cycle; a request SHALL never be withdrawn.
REQ-015 On ack in WAIT without redirect, {imem_rdata, fetch_pc} SHALL be pushed, fetch_pc += 4 modulo 2^32 (0xFFFF_FFFC wraps to 0), and the FSM SHALL return to IDLE.
REQ-016 At most one request SHALL be outstanding; an outstanding request reserves a buffer slot, so a new request issues only if count+1 <= DEPTH after the current response, guaranteeing no overflow.
REQ-017 Redirect SHALL take priority over push and pop in its cycle: buffer flushed (count=0, inst_valid=0 next cycle), fetch_pc=redirect_pc.
REQ-018 Redirect in WAIT without ack SHALL move the FSM to DROP; redirect in the ack cycle SHALL discard that response and go to IDLE.
REQ-019 Ack in DROP SHALL discard the response and return to IDLE; fetch_pc is not incremented.
REQ-020 Latency: redirect in cycle N with no outstanding request SHALL yield imem_req with imem_addr=redirect_pc in cycle N+1; ack in cycle M SHALL yield inst_valid=1 in cycle M+1 if the buffer was empty.
REQ-021 inst_valid SHALL equal (count != 0); inst/inst_pc SHALL be the head entry; a pop and a push in the same cycle SHALL both take effect, leaving count unchanged.
REQ-022 The buffer SHALL be a circular FIFO with read/write pointers of log2(DEPTH) bits that wrap naturally.

Reset
REQ-023 While reset=0: fetch_pc=RESET_PC, FSM=IDLE, count=0, pointers=0, imem_req=0, inst_valid=0, imem_addr=RESET_PC, fetch_misalign=0.
REQ-024 The first request after reset deassertion SHALL issue on the first clk edge at which reset=1, with imem_addr=RESET_PC.
REQ-025 Reset asserted mid-request SHALL abandon it immediately; the memory side SHALL ignore a stale ack arriving after reset.

Configuration
REQ-026 With FETCH_ALIGN_CHECK_EN defined, output fetch_misalign (1 bit) SHALL go high in the cycle after a redirect with redirect_pc[1:0] != 0, stay high, and block new requests until the next aligned redirect clears it.
REQ-027 Without FETCH_ALIGN_CHECK_EN, port fetch_misalign SHALL be absent and redirect_pc[1:0] SHALL be forced to 2'b00.

Structure
REQ-028 A shared package SHALL hold the FSM state encoding (IDLE, WAIT, DROP), RESET_PC default, and the instruction-width constant (32).
REQ-029 The FIFO SHALL be a sub-module named fetch_fifo (data+pc storage, pointers, count, flush input); the FSM and fetch_pc live in fetch_unit.

Verification
REQ-030 Reset release, ack next cycle with rdata 32'h3C01_0001 -> imem_addr=0x3000, then inst_valid=1, inst=0x3C01_0001, inst_pc=0x3000, next request at 0x3004.
REQ-031 inst_ready=0, immediate acks, DEPTH=4 -> exactly 4 words buffered (pc 0x3000..0x300C), imem_req stays 0 until a pop.
REQ-032 Redirect to 0x0000_3100 while WAIT, ack two cycles later -> acked word discarded, buffer empty, next imem_addr=0x3100.
REQ-033 Redirect in the ack cycle with full buffer and inst_ready=1 -> no push or pop retained, inst_valid=0 next cycle, fetch_pc=redirect_pc.
REQ-034 Redirect to 0xFFFF_FFFC, ack -> next imem_addr=0x0000_0000.
REQ-035 With FETCH_ALIGN_CHECK_EN, redirect to 0x3002 -> fetch_misalign=1, no imem_req; redirect to 0x3008 -> fetch_misalign=0, imem_addr=0x3008.
